// File: rtl/meas_queue_if.sv
// meas_queue_if: measurement push side and uart_tx launch side of meas_queue
interface meas_queue_if #(
  parameter int DATA_W = 40,
  parameter int DEPTH_LOG2 = 3,
  parameter int DROP_W = 16
);
  logic [DATA_W-1:0] meas_in;
  logic meas_valid;
  logic uart_busy;
  logic [DATA_W-1:0] uart_data;
  logic uart_start;
  logic [DEPTH_LOG2:0] level;
  logic full;
  logic empty;
  logic [DROP_W-1:0] drop_count;
  modport master (
    output meas_in, meas_valid, uart_busy,
    input uart_data, uart_start, level, full, empty, drop_count
  );
  modport slave (
    input meas_in, meas_valid, uart_busy,
    output uart_data, uart_start, level, full, empty, drop_count
  );
endinterface

// File: rtl/meas_queue.sv
// meas_queue: 200 MHz measurement FIFO feeding uart_tx; MEAS_QUEUE_DROP_CNT_EN enables the saturating drop counter
module meas_queue #(
  parameter int DATA_W = 40,
  parameter int DEPTH_LOG2 = 3,
  parameter int DROP_W = 16
) (
  input logic clk,
  input logic rst_n,
  meas_queue_if.slave q
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] level;
  logic [DATA_W-1:0] uart_data;
  logic uart_start;
  logic full, empty, pop, push;
  assign full = level[DEPTH_LOG2];
  assign empty = level == '0;
  assign pop = state == IDLE && !empty && !q.uart_busy;
  // a full queue still takes the push when the slot is freed in the same cycle
  assign push = q.meas_valid && (!full || pop);
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = pop ? WAIT_BUSY : IDLE;
    else if (state == WAIT_BUSY) state_nx = q.uart_busy ? WAIT_DONE : WAIT_BUSY;
    else state_nx = q.uart_busy ? WAIT_DONE : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      uart_data <= '0;
      uart_start <= 1'b0;
    end else begin
      state <= state_nx;
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level <= level + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
      uart_start <= pop;
      if (pop) uart_data <= mem[rd_ptr];
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= q.meas_in;
`ifdef MEAS_QUEUE_DROP_CNT_EN
  logic [DROP_W-1:0] drop_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_count <= '0;
    else if (q.meas_valid && !push && drop_count != '1) drop_count <= drop_count + 1'b1;
  assign q.drop_count = drop_count;
`else
  assign q.drop_count = DROP_W'(0);
`endif
  assign q.uart_data = uart_data;
  assign q.uart_start = uart_start;
  assign q.level = level;
  assign q.full = full;
  assign q.empty = empty;
endmodule

// File: tb/tb_meas_queue.sv
// tb_meas_queue: randomized and directed stimulus for meas_queue against a queue-level model with a decoupled scoreboard
module tb_meas_queue;
  localparam int DW = 40;
  localparam int DL = 3;
  localparam int DEPTH = 1 << DL;
  localparam int DROP_W = 2;
  localparam int DROP_MAX = (1 << DROP_W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  meas_queue_if #(.DATA_W(DW), .DEPTH_LOG2(DL), .DROP_W(DROP_W)) qi ();
  meas_queue #(.DATA_W(DW), .DEPTH_LOG2(DL), .DROP_W(DROP_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .q(qi)
  );
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] st[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_data = '0;
  int drops = 0;
  int ph = 0;
  int fr_left = 0;
  int dly = 0;
  int frame_len = 20;
  int dly_max = 1;
  bit hold = 1'b0;
  bit exp_start = 1'b0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int exp_drop();
`ifdef MEAS_QUEUE_DROP_CNT_EN
    return drops > DROP_MAX ? DROP_MAX : drops;
`else
    return 0;
`endif
  endfunction
  // ph tracks the frame in flight: 0 none, 1 launched and waiting for busy, 2 busy seen
  task automatic step(input bit v, input logic [DW-1:0] d);
    bit b, pop, acc;
    @(negedge clk);
    b = hold || fr_left > 0;
    qi.meas_valid = v;
    qi.meas_in = d;
    qi.uart_busy = b;
    pop = ph == 0 && st.size() > 0 && !b;
    acc = v && (st.size() < DEPTH || pop);
    exp_start = pop;
    if (pop) exp_q.push_back(st.pop_front());
    if (acc) st.push_back(d);
    else if (v) drops++;
    if (fr_left > 0) fr_left--;
    else if (dly > 0) begin
      dly--;
      if (dly == 0) fr_left = frame_len;
    end
    ph = pop ? 1 : (ph == 1 && b) ? 2 : (ph == 2 && !b) ? 0 : ph;
    if (pop) dly = 1 + int'($urandom_range(0, dly_max - 1));
  endtask
  task automatic drain();
    int n = 0;
    hold = 1'b0;
    while ((st.size() > 0 || exp_q.size() > 0 || ph != 0 || fr_left > 0 || dly > 0) && n < 3000) begin
      step(1'b0, '0);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d words still pending, expected 0", st.size() + exp_q.size());
    end
  endtask
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    qi.meas_valid = 1'b0;
    qi.uart_busy = 1'b0;
    st.delete();
    exp_q.delete();
    drops = 0;
    ph = 0;
    fr_left = 0;
    dly = 0;
    hold = 1'b0;
    exp_start = 1'b0;
    last_data = '0;
    #1;
    chk("rst_start", 64'(qi.uart_start), 64'd0);
    chk("rst_data", 64'(qi.uart_data), 64'd0);
    chk("rst_level", 64'(qi.level), 64'd0);
    chk("rst_empty", 64'(qi.empty), 64'd1);
    chk("rst_full", 64'(qi.full), 64'd0);
    chk("rst_drop", 64'(qi.drop_count), 64'd0);
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask
  always @(posedge clk) begin
    #1;
    chk("level", 64'(qi.level), 64'(st.size()));
    chk("full", 64'(qi.full), 64'(st.size() == DEPTH));
    chk("empty", 64'(qi.empty), 64'(st.size() == 0));
    chk("drop_count", 64'(qi.drop_count), 64'(exp_drop()));
    chk("uart_start", 64'(qi.uart_start), 64'(exp_start));
    if (qi.uart_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_start: got data %0h with no word expected", qi.uart_data);
      end else begin
        last_data = exp_q.pop_front();
        chk("uart_data", 64'(qi.uart_data), 64'(last_data));
      end
    end else chk("data_hold", 64'(qi.uart_data), 64'(last_data));
  end
  initial begin
    qi.meas_valid = 1'b0;
    qi.meas_in = '0;
    qi.uart_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 40'h00_0000_1234);
    repeat (30) step(1'b0, '0);
    drain();
    hold = 1'b1;
    for (int i = 1; i <= 10; i++) step(1'b1, DW'(i));
    step(1'b0, '0);
    frame_len = 4;
    drain();
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'h100 + i));
    step(1'b0, '0);
    hold = 1'b0;
    step(1'b1, 40'hAA);
    drain();
    hold = 1'b1;
    for (int i = 0; i < DEPTH + 6; i++) step(1'b1, DW'(32'h200 + i));
    step(1'b0, '0);
    drain();
    frame_len = 20;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, DW'(32'h300 + i));
    hold = 1'b0;
    repeat (6) step(1'b0, '0);
    do_reset(2);
    repeat (12) step(1'b0, '0);
    dly_max = 3;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) hold = !hold;
      frame_len = 1 + int'($urandom_range(0, 5));
      step(1'($urandom_range(0, 1)), {8'($urandom()), $urandom()});
    end
    drain();
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
